// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the memory-stage data-memory responder.
// Holds the FSM encoding, wait counter width and the wide-transfer word order.
package data_mem_responder_pkg;

  localparam int WAIT_CNT_W = 4;

  // Wide transfers keep the high half at the lower address, matching SP push order.
  localparam bit HI_AT_ADDR = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    BEAT0 = 3'd2,
    BEAT1 = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic logic beat_is_hi(input logic second_beat);
    return HI_AT_ADDR ? !second_beat : second_beat;
  endfunction

endpackage

// File: rtl/dmem_array_sync.sv
// Single-port synchronous RAM: write and registered read on the rising edge.
// Read data holds between read enables; contents are never reset.
module dmem_array_sync #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, response WAIT_STATES+2 (narrow) or +3 (wide) cycles after accept.
// ReqReady only in IDLE; requests offered while busy are ignored, not queued.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 11,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic              ReqWide,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              RspValid,
  output logic [31:0]       RspRData,
  output logic              RspError,
  output logic              Busy
);

  localparam logic [ADDR_W-1:0]     DEPTH_WORDS = ADDR_W'(1) << DEPTH_LOG2;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;
  localparam state_t                AFTER_ACCEPT = (WAIT_STATES > 0) ? WAIT : BEAT0;

  state_t                  state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    accept;
  logic                    req_err;

  logic                    cap_write;
  logic                    cap_wide;
  logic                    cap_err;
  logic [DEPTH_LOG2-1:0]   cap_addr;
  logic [31:0]             cap_wdata;

  logic                    second_beat;
  logic                    in_beat;
  logic                    use_hi;
  logic                    ram_we;
  logic                    ram_re;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_W-1:0]       ram_wdata;
  logic [DATA_W-1:0]       ram_rdata;
  logic [DATA_W-1:0]       first_q;

  logic [31:0]             fresh_rdata;
  logic [31:0]             held_rdata;
  logic                    rsp_valid_q;
  logic                    rsp_error_q;
  logic                    busy_q;

  assign ReqReady = (state == IDLE) & Reset;
  assign accept   = ReqValid & ReqReady;

  // A wide request needs Addr+1 in range too; there is no wrap-around.
  assign req_err = ReqWide ? (ReqAddr >= DEPTH_WORDS - ADDR_W'(1))
                           : (ReqAddr >= DEPTH_WORDS);

  always_ff @(posedge CLK) begin
    if (accept) begin
      cap_write <= ReqWrite;
      cap_wide  <= ReqWide;
      cap_err   <= req_err;
      cap_addr  <= ReqAddr[DEPTH_LOG2-1:0];
      cap_wdata <= ReqWData;
    end
  end

  assign second_beat = (state == BEAT1);
  assign in_beat     = (state == BEAT0) | second_beat;
  assign use_hi      = cap_wide & beat_is_hi(second_beat);
  assign ram_addr    = cap_addr + DEPTH_LOG2'(second_beat);
  assign ram_wdata   = use_hi ? cap_wdata[DATA_W +: DATA_W] : cap_wdata[DATA_W-1:0];
  // Gating with Reset keeps an aborted beat from landing in the array.
  assign ram_we      = Reset & in_beat & cap_write & ~cap_err;
  assign ram_re      = Reset & in_beat & ~cap_write & ~cap_err;

  dmem_array_sync #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register still holds the first beat while BEAT1 reads the second.
  always_ff @(posedge CLK) begin
    if (second_beat) first_q <= ram_rdata;
  end

  always_comb begin
    fresh_rdata = '0;
    if (!cap_err && !cap_write) begin
      if (cap_wide) fresh_rdata = HI_AT_ADDR ? {first_q, ram_rdata} : {ram_rdata, first_q};
      else          fresh_rdata = 32'(ram_rdata);
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      held_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= AFTER_ACCEPT;
            wait_cnt <= WAIT_LOAD;
            busy_q   <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= BEAT0;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        BEAT0: begin
          if (cap_wide) begin
            state <= BEAT1;
          end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= cap_err;
          end
        end
        BEAT1: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_error_q <= cap_err;
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          held_rdata  <= fresh_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is live from the RAM register during RESP, then frozen until the next RESP.
  assign RspRData = (state == RESP) ? fresh_rdata : held_rdata;
  assign RspValid = rsp_valid_q;
  assign RspError = rsp_error_q;
  assign Busy     = busy_q;

endmodule
